// File: rtl/jtag_types_pkg.sv
// Shared command/state types and TAP state-walk tables for the JTAG host.
package jtag_types_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_IR    = 2'd1,
        CMD_DR    = 2'd2,
        CMD_IDLE  = 2'd3
    } jtag_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TRL,
        S_RSP
    } jtag_master_state_t;

    localparam logic [2:0] HDR_LEN_RESET = 3'd5;
    localparam logic [2:0] TRL_LEN_RESET = 3'd1;
    localparam logic [2:0] HDR_LEN_IR    = 3'd4;
    localparam logic [2:0] TRL_LEN_IR    = 3'd2;
    localparam logic [2:0] HDR_LEN_DR    = 3'd3;
    localparam logic [2:0] TRL_LEN_DR    = 3'd2;

    // TMS value for each header/trailer TCK; entry 0 sits in bit 0.
    localparam logic [7:0] HDR_TMS_RESET = 8'b0001_1111;
    localparam logic [7:0] HDR_TMS_IR    = 8'b0000_0011;
    localparam logic [7:0] HDR_TMS_DR    = 8'b0000_0001;
    localparam logic [7:0] TRL_TMS_RESET = 8'b0000_0000;
    localparam logic [7:0] TRL_TMS_SCAN  = 8'b0000_0001;

    function automatic logic [2:0] hdr_len(jtag_cmd_t op);
        case (op)
            CMD_RESET: return HDR_LEN_RESET;
            CMD_IR:    return HDR_LEN_IR;
            CMD_DR:    return HDR_LEN_DR;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] trl_len(jtag_cmd_t op);
        case (op)
            CMD_RESET: return TRL_LEN_RESET;
            CMD_IR:    return TRL_LEN_IR;
            CMD_DR:    return TRL_LEN_DR;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic hdr_tms(jtag_cmd_t op, logic [2:0] idx);
        case (op)
            CMD_RESET: return HDR_TMS_RESET[idx];
            CMD_IR:    return HDR_TMS_IR[idx];
            CMD_DR:    return HDR_TMS_DR[idx];
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic trl_tms(jtag_cmd_t op, logic [2:0] idx);
        case (op)
            CMD_RESET:      return TRL_TMS_RESET[idx];
            CMD_IR, CMD_DR: return TRL_TMS_SCAN[idx];
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles TCK every TCK_HALF clk cycles while enabled, idles low otherwise.
module jtag_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic nRST,
    input  logic enable,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          half_done;

    // Strobes are true in the cycle whose closing clk edge moves TCK.
    assign half_done = enable && (cnt_q == CW'(TCK_HALF - 1));
    assign rise      = half_done && !tck_q;
    assign fall      = half_done && tck_q;
    assign tck       = tck_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!enable) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (half_done) begin
            cnt_q <= '0;
            tck_q <= !tck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// Word-level JTAG TAP host: serialises reset/IR/DR/idle commands onto TCK/TMS/TDI.
module jtag_master #(
    parameter int MAX_LEN  = 32,
    parameter int TCK_HALF = 2,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    import jtag_types_pkg::*;

    jtag_master_state_t state_q;
    jtag_cmd_t          op_q;
    jtag_cmd_t          cmd_op_t;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bit_q;
    logic [2:0]         idx_q;
    logic [MAX_LEN-1:0] sh_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               tms_q;
    logic               tdi_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               cmd_bad;
    logic               accept;
    logic               tck_en;
    logic               tck_rise;
    logic               tck_fall;

    assign cmd_op_t  = jtag_cmd_t'(cmd_op);
    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_op_t != CMD_RESET)
                       && ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN)));
    assign tck_en    = state_q inside {S_HDR, S_SHIFT, S_TRL};

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

    jtag_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck_gen (
        .clk   (clk),
        .nRST  (nRST),
        .enable(tck_en),
        .tck   (TCK),
        .rise  (tck_rise),
        .fall  (tck_fall)
    );

    // Pins for the next TCK are loaded on the fall strobe that ends the current one.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            op_q        <= CMD_RESET;
            len_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            mask_q      <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= cmd_op_t;
                        len_q      <= cmd_len;
                        bit_q      <= cmd_len;
                        idx_q      <= '0;
                        sh_q       <= cmd_data;
                        mask_q     <= MAX_LEN'(1);
                        rsp_err_q  <= cmd_bad;
                        rsp_data_q <= '0;
                        if (cmd_bad) begin
                            state_q <= S_RSP;
                        end else if (cmd_op_t == CMD_IDLE) begin
                            state_q <= S_SHIFT;
                            tms_q   <= 1'b0;
                            tdi_q   <= 1'b0;
                        end else begin
                            state_q <= S_HDR;
                            tms_q   <= hdr_tms(cmd_op_t, 3'd0);
                            tdi_q   <= 1'b0;
                        end
                    end
                end
                S_HDR: begin
                    if (tck_fall) begin
                        if (idx_q == hdr_len(op_q) - 3'd1) begin
                            if (op_q == CMD_RESET) begin
                                state_q <= S_TRL;
                                idx_q   <= '0;
                                tms_q   <= trl_tms(op_q, 3'd0);
                                tdi_q   <= 1'b0;
                            end else begin
                                state_q <= S_SHIFT;
                                tms_q   <= (len_q == LEN_W'(1));
                                tdi_q   <= sh_q[0];
                            end
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tms_q <= hdr_tms(op_q, idx_q + 3'd1);
                        end
                    end
                end
                S_SHIFT: begin
                    if (tck_rise && (op_q != CMD_IDLE) && TDO) begin
                        rsp_data_q <= rsp_data_q | mask_q;
                    end
                    if (tck_fall) begin
                        sh_q   <= sh_q >> 1;
                        mask_q <= mask_q << 1;
                        bit_q  <= bit_q - 1'b1;
                        if (bit_q == LEN_W'(1)) begin
                            tdi_q <= 1'b0;
                            if (op_q == CMD_IDLE) begin
                                state_q <= S_RSP;
                                tms_q   <= 1'b0;
                            end else begin
                                state_q <= S_TRL;
                                idx_q   <= '0;
                                tms_q   <= trl_tms(op_q, 3'd0);
                            end
                        end else begin
                            tms_q <= (op_q != CMD_IDLE) && (bit_q == LEN_W'(2));
                            tdi_q <= (op_q != CMD_IDLE) && sh_q[1];
                        end
                    end
                end
                S_TRL: begin
                    if (tck_fall) begin
                        if (idx_q == trl_len(op_q) - 3'd1) begin
                            state_q <= S_RSP;
                            tms_q   <= 1'b0;
                            tdi_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tms_q <= trl_tms(op_q, idx_q + 3'd1);
                        end
                    end
                end
                S_RSP: begin
                    // First cycle arms the pulse, second cycle drops it and frees the master.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jtag_master.md
# jtag_master

Clock-domain TAP host that sits directly upstream of the `jtag` top block and generates its `TCK`/`TMS`/`TDI` pin stimulus from word-level commands. It samples `TDO` on the returned bit stream. A command (TAP reset, IR scan, DR scan, idle clocks) is accepted over a valid/ready handshake, serialised onto the pins with correct TAP state-walk headers and trailers, and answered with a single-cycle response carrying the captured `TDO` bits. It lets system logic or a testbench drive the boundary-scan chain without hand-built pin sequences.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum scan length in bits
- `TCK_HALF`, 2: `clk` cycles per TCK half-period (≥1)
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of the length field

Ports:
- `clk`  in  1  system clock; the only clock.
- `nRST`  in  1  reset. Asynchronous, active-low.
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  master can accept a command
- `cmd_op`  in  2  `jtag_cmd_t`: `CMD_RESET`=0, `CMD_IR`=1, `CMD_DR`=2, `CMD_IDLE`=3
- `cmd_len`  in  LEN_W  scan length, or TCK count for `CMD_IDLE`
- `cmd_data`  in  MAX_LEN  TDI bits; bit 0 is shifted first
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  command rejected (qualified by `rsp_valid`)
- `rsp_data`  out  MAX_LEN  captured TDO; bit i is the i-th shift bit; bits ≥ len are 0
- `TCK`, `TMS`, `TDI`  out  1  TAP pins, all registered
- `TDO`  in  1  TAP serial out

## Operation
**Reset values:** `TCK`=0, `TMS`=1, `TDI`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0. FSM goes to `S_IDLE`, so `cmd_ready`=1.

**Handshake:**
- A command is accepted on a `clk` edge where `cmd_valid && cmd_ready`. All fields are latched at that edge.
- `cmd_ready` = (state == `S_IDLE`).

**Error check:** for `CMD_IR`, `CMD_DR` and `CMD_IDLE`, `cmd_len`==0 or `cmd_len`>`MAX_LEN` is rejected:
- no pin activity;
- go to `S_RSP`;
- `rsp_err`=1, `rsp_data`=0.

**TAP state:** the master assumes the TAP is in Run-Test/Idle between commands. Software must issue `CMD_RESET` first after `nRST`.

**TMS sequences** (one entry per TCK; N = len):
- `CMD_RESET`: 1,1,1,1,1,0. 6 TCKs.
- `CMD_IR`: 1,1,0,0, then N shift bits with TMS=0 except the last bit TMS=1, then 1,0. N+6 TCKs.
- `CMD_DR`: 1,0,0, then N shift bits as above, then 1,0. N+5 TCKs.
- `CMD_IDLE`: N TCKs with TMS=0.

**TDI and TDO:**
- `TDI` = `cmd_data[i]` during shift bit i; 0 on all other TCKs.
- `TDO` is sampled only during shift bits.

**FSM:** `S_IDLE` → `S_HDR` → `S_SHIFT` → `S_TRL` → `S_RSP` → `S_IDLE`.
- `CMD_RESET` skips `S_SHIFT`.
- `CMD_IDLE` uses `S_SHIFT` without sampling.
- A bit counter and a header/trailer index select the TMS value.

**Response:** `rsp_valid` is high for exactly one cycle, in `S_RSP`. `rsp_data` and `rsp_err` hold until the next accept.

**Back-to-back:** a new command may be accepted the cycle after `rsp_valid`.

## Timing
**Per-bit timing:** each TCK bit spans 2·`TCK_HALF` clks.
- `TMS`/`TDI` update only on the clk edge that drives `TCK` low, or on the first bit edge.
- `TCK` rises `TCK_HALF` clks after the bit starts.
- `TDO` is sampled on the same clk edge that sets `TCK`=1.
- `TMS`/`TDI` never change coincident with a TCK rise.

**Latency:**
- Bit 0 pins are valid the cycle after accept, with `TCK` low.
- `rsp_valid` rises 1 + T·2·`TCK_HALF` cycles after the accept edge, where T is the total TCK count.
- Rejected commands: `rsp_valid` on the cycle after accept.
- `TCK` idles low whenever there is no command.

**Reset during a command:** outputs go to reset values immediately and asynchronously. The command is dropped and no `rsp_valid` is produced.

**Ignored inputs:** `cmd_valid` while `cmd_ready`=0 is ignored; there is no queueing.

## Structure
- Add to `jtag_types_pkg`:
  - `jtag_cmd_t` enum;
  - `jtag_master_state_t` (`S_IDLE`, `S_HDR`, `S_SHIFT`, `S_TRL`, `S_RSP`);
  - header/trailer length constants (reset 5+1, IR 4/2, DR 3/2).
- Sub-module `jtag_tck_gen` (`clk`, `nRST`, enable):
  - contains the half-period counter;
  - outputs `tck`, a `rise` strobe and a `fall` strobe;
  - the FSM advances only on the strobes.

## Test plan
1. **Reset values:** hold `nRST` low → `TCK`=0, `TMS`=1, `TDI`=0, `cmd_ready`=1, `rsp_valid`=0.
2. **TAP reset:** `CMD_RESET` → exactly 6 TCK rises with TMS 1,1,1,1,1,0 at the rises; `rsp_valid` pulses once; `rsp_data`=0.
3. **DR scan:** behavioural TAP model with its 8-bit DR preloaded to 8'hA5. Command `CMD_DR`, len 8, data 8'h3C, `TCK_HALF`=2 →
   - TMS 1,0,0,0×7,1,1,0 (13 TCKs);
   - `rsp_data`=8'hA5;
   - model DR = 8'h3C after Update-DR;
   - `rsp_valid` 53 cycles after accept.
4. **IR scan:** `CMD_IR`, len 4, data 4'hB → 10 TCKs with TMS 1,1,0,0,0,0,0,1,1,0; TDI at the shift rises 1,1,0,1.
5. **Length errors:** `CMD_DR` with len 0, then with len 33 → each gives `rsp_valid`+`rsp_err` one cycle after accept and no TCK edge. Follow immediately with `CMD_IDLE` len 3 → exactly 3 TCKs, TMS=0, `rsp_err`=0.
6. **Reset mid-scan:** assert `nRST` during shift bit 3 of a DR scan → pins return to reset values within the same cycle; no `rsp_valid`. After release, `cmd_ready`=1 and a `CMD_RESET` completes normally.
